// File: rtl/ethernet_pkg.sv
// Shared types and constants for the Ethernet TX path.
//   ETH_AXIS64_T    : one 64-bit AXI-Stream beat {tdata, tkeep, tlast, tuser}
//   ETH_ABORT_BEAT  : error-tagged tail beat injected when a frame is cut off
//   ETH_ARB_STATE_T : TX arbiter frame state
package ethernet_pkg;

  localparam int unsigned ETH_DATA_W = 64;
  localparam int unsigned ETH_KEEP_W = ETH_DATA_W / 8;

  typedef struct packed {
    logic [ETH_DATA_W-1:0] tdata;
    logic [ETH_KEEP_W-1:0] tkeep;
    logic                  tlast;
    logic                  tuser;
  } ETH_AXIS64_T;

  localparam logic [ETH_DATA_W-1:0] ETH_ABORT_TDATA = '0;
  localparam logic [ETH_KEEP_W-1:0] ETH_ABORT_TKEEP = 8'h01;

  // Single-byte tail with tuser set: the MAC discards the whole frame.
  localparam ETH_AXIS64_T ETH_ABORT_BEAT = '{
    tdata: ETH_ABORT_TDATA,
    tkeep: ETH_ABORT_TKEEP,
    tlast: 1'b1,
    tuser: 1'b1
  };

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ABORT,
    DRAIN
  } ETH_ARB_STATE_T;

endpackage

// File: rtl/axis_skid.sv
// Two-entry AXI-Stream register slice.
//   clk, rst_n         : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data : upstream side (s_ready is a pure flop output)
//   m_valid/m_ready/m_data : downstream side (registered)
// Full throughput; the skid entry absorbs the one beat accepted while the
// output is stalled, so no combinational path exists from m_ready to s_ready.
module axis_skid
  import ethernet_pkg::*;
#(
  parameter type T = ETH_AXIS64_T
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_valid,
  output logic s_ready,
  input  T     s_data,
  output logic m_valid,
  input  logic m_ready,
  output T     m_data
);

  logic out_valid_q, out_valid_d;
  T     out_q, out_d;
  logic skid_valid_q, skid_valid_d;
  T     skid_q, skid_d;

  assign s_ready = ~skid_valid_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (m_ready || !out_valid_q) begin
      if (skid_valid_q) begin
        // s_ready is low this cycle, so nothing new arrives while refilling.
        out_valid_d  = 1'b1;
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = s_valid;
        if (s_valid) out_d = s_data;
      end
    end else if (s_valid && s_ready) begin
      skid_valid_d = 1'b1;
      skid_d       = s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-level round-robin arbiter onto the shared 64-bit Ethernet TX stream.
//   eth_clk, eth_rst_n : clock, asynchronous active-low reset
//   s_*                : NPORT packed source streams (source i at slice i)
//   eth_tx_*           : registered stream to the MAC
//   grant_idx          : current or last granted source
//   busy               : a frame is in progress (GRANT, ABORT or DRAIN)
//   abort_cnt          : saturating count of watchdog aborts
// A granted source idle mid-frame for TIMEOUT cycles is cut off: an abort
// tail beat is sent and the rest of its frame is swallowed.
module eth_tx_arbiter
  import ethernet_pkg::*;
#(
  parameter int unsigned NPORT   = 3,
  parameter int unsigned DATA_W  = 64,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic                      eth_clk,
  input  logic                      eth_rst_n,
  input  logic [NPORT-1:0]          s_tvalid,
  output logic [NPORT-1:0]          s_tready,
  input  logic [NPORT*DATA_W-1:0]   s_tdata,
  input  logic [NPORT*DATA_W/8-1:0] s_tkeep,
  input  logic [NPORT-1:0]          s_tlast,
  input  logic [NPORT-1:0]          s_tuser,
  input  logic                      eth_tx_tready,
  output logic                      eth_tx_tvalid,
  output logic [DATA_W-1:0]         eth_tx_tdata,
  output logic [DATA_W/8-1:0]       eth_tx_tkeep,
  output logic                      eth_tx_tlast,
  output logic                      eth_tx_tuser,
  output logic [$clog2(NPORT)-1:0]  grant_idx,
  output logic                      busy,
  output logic [15:0]               abort_cnt
);

  localparam int unsigned IDX_W  = $clog2(NPORT);
  localparam int unsigned KEEP_W = DATA_W / 8;

  ETH_ARB_STATE_T state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [15:0]      wd_q, wd_d;
  logic [15:0]      abort_q, abort_d;

  logic             src_valid;
  ETH_AXIS64_T      src_beat;
  logic             rdy_g;
  logic             found_hi, found_lo;
  logic [IDX_W-1:0] pick_hi, pick_lo, pick, gnt_next;
  logic             skid_in_valid, skid_in_ready;
  ETH_AXIS64_T      skid_in, skid_out;

  always_comb begin
    src_valid = 1'b0;
    src_beat  = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (gnt_q == IDX_W'(i)) begin
        src_valid      = s_tvalid[i];
        src_beat.tdata = s_tdata[i*DATA_W +: DATA_W];
        src_beat.tkeep = s_tkeep[i*KEEP_W +: KEEP_W];
        src_beat.tlast = s_tlast[i];
        src_beat.tuser = s_tuser[i];
      end
    end
  end

  // Round-robin pick: first requester at or above rr_q, else the lowest one.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (s_tvalid[i] && !found_hi && IDX_W'(i) >= rr_q) begin
        found_hi = 1'b1;
        pick_hi  = IDX_W'(i);
      end
      if (s_tvalid[i] && !found_lo) begin
        found_lo = 1'b1;
        pick_lo  = IDX_W'(i);
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  assign gnt_next = (gnt_q == IDX_W'(NPORT-1)) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    rr_d          = rr_q;
    wd_d          = wd_q;
    abort_d       = abort_q;
    rdy_g         = 1'b0;
    skid_in_valid = 1'b0;
    skid_in       = src_beat;
    unique case (state_q)
      IDLE: begin
        if (found_lo) begin
          gnt_d   = pick;
          wd_d    = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        rdy_g         = skid_in_ready;
        skid_in_valid = src_valid;
        if (src_valid && skid_in_ready) begin
          wd_d = '0;
          if (src_beat.tlast) begin
            rr_d    = gnt_next;
            state_d = IDLE;
          end
        end else if (!src_valid && wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
        // An accepted tlast in the firing cycle completes the frame instead.
        if (TIMEOUT != '0 && wd_q == TIMEOUT &&
            !(src_valid && skid_in_ready && src_beat.tlast)) begin
          state_d = ABORT;
          if (abort_q != '1) abort_d = abort_q + 1'b1;
        end
      end
      ABORT: begin
        skid_in_valid = 1'b1;
        skid_in       = ETH_ABORT_BEAT;
        if (skid_in_ready) state_d = DRAIN;
      end
      DRAIN: begin
        rdy_g = 1'b1;
        if (src_valid && src_beat.tlast) begin
          rr_d    = gnt_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_tready = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      s_tready[i] = rdy_g && (gnt_q == IDX_W'(i));
    end
  end

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
      abort_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
      abort_q <= abort_d;
    end
  end

  axis_skid #(
    .T(ETH_AXIS64_T)
  ) u_out_stage (
    .clk    (eth_clk),
    .rst_n  (eth_rst_n),
    .s_valid(skid_in_valid),
    .s_ready(skid_in_ready),
    .s_data (skid_in),
    .m_valid(eth_tx_tvalid),
    .m_ready(eth_tx_tready),
    .m_data (skid_out)
  );

  assign eth_tx_tdata = skid_out.tdata;
  assign eth_tx_tkeep = skid_out.tkeep;
  assign eth_tx_tlast = skid_out.tlast;
  assign eth_tx_tuser = skid_out.tuser;
  assign grant_idx    = gnt_q;
  assign busy         = (state_q != IDLE);
  assign abort_cnt    = abort_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter (3 ports, 64-bit, TIMEOUT = 8).
module tb_eth_tx_arbiter;

  localparam int NP = 3;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
    int          gap;
  } beat_t;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
    int          cyc;
  } obeat_t;

  typedef struct {
    int          src;
    int          nb;
    logic [7:0]  last_keep;
    logic        last_user;
    logic [1:0]  exp_grant;
    int          exp_lat;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [NP-1:0] s_tvalid, s_tready, s_tlast, s_tuser;
  logic [NP*64-1:0] s_tdata;
  logic [NP*8-1:0]  s_tkeep;
  logic          eth_tx_tready, eth_tx_tvalid, eth_tx_tlast, eth_tx_tuser;
  logic [63:0]   eth_tx_tdata;
  logic [7:0]    eth_tx_tkeep;
  logic [1:0]    grant_idx;
  logic          busy;
  logic [15:0]   abort_cnt;

  beat_t  srcq[NP][$];
  obeat_t outq[$];
  int     rise_cyc[NP];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  bit     bp_mode = 0;

  eth_tx_arbiter #(
    .NPORT  (3),
    .DATA_W (64),
    .TIMEOUT(16'd8)
  ) dut (
    .eth_clk      (clk),
    .eth_rst_n    (rst_n),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .s_tkeep      (s_tkeep),
    .s_tlast      (s_tlast),
    .s_tuser      (s_tuser),
    .eth_tx_tready(eth_tx_tready),
    .eth_tx_tvalid(eth_tx_tvalid),
    .eth_tx_tdata (eth_tx_tdata),
    .eth_tx_tkeep (eth_tx_tkeep),
    .eth_tx_tlast (eth_tx_tlast),
    .eth_tx_tuser (eth_tx_tuser),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .abort_cnt    (abort_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mk(input int src, input int fr, input int bt);
    return {8'(src), 40'h0, 8'(fr), 8'(bt)};
  endfunction

  task automatic push_beat(input int src, input logic [63:0] d, input logic [7:0] k,
                           input logic l, input logic u, input int gap);
    beat_t x;
    x.d = d; x.k = k; x.l = l; x.u = u; x.gap = gap;
    srcq[src].push_back(x);
  endtask

  task automatic push_frame(input int src, input int fr, input int nb,
                            input logic [7:0] lk, input logic lu);
    for (int b = 0; b < nb; b++) begin
      push_beat(src, mk(src, fr, b), (b == nb-1) ? lk : 8'hFF, b == nb-1,
                (b == nb-1) ? lu : 1'b0, 0);
    end
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int w = 0;
    while (outq.size() < n && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk(name, 64'(outq.size() >= n), 64'd1);
  endtask

  task automatic chk_beat(input string name, input int idx, input logic [63:0] d,
                          input logic [7:0] k, input logic l, input logic u);
    if (idx < outq.size()) begin
      chk({name, "_data"}, outq[idx].d, d);
      chk({name, "_ctl"}, {outq[idx].k, outq[idx].l, outq[idx].u}, {k, l, u});
    end else begin
      chk({name, "_missing"}, 64'(outq.size()), 64'(idx + 1));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #3;
    outq.delete();
  endtask

  // Source driver (posedge + 1) and output monitor (negedge).
  initial begin
    logic [NP-1:0] acc;
    obeat_t cur, pv;
    bit     stalled;
    beat_t  b;
    acc = '0; stalled = 0;
    s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0; s_tkeep = '0;
    eth_tx_tready = 1'b1;
    forever begin
      @(negedge clk);
      acc = s_tvalid & s_tready;
      cur.d = eth_tx_tdata; cur.k = eth_tx_tkeep; cur.l = eth_tx_tlast;
      cur.u = eth_tx_tuser; cur.cyc = cyc;
      if (rst_n) begin
        if (stalled) begin
          chk("hold_valid", 64'(eth_tx_tvalid), 64'd1);
          chk("hold_beat", {cur.d[55:0], cur.k, cur.l, cur.u}, {pv.d[55:0], pv.k, pv.l, pv.u});
        end
        if (eth_tx_tvalid && eth_tx_tready) outq.push_back(cur);
        stalled = eth_tx_tvalid && !eth_tx_tready;
        pv = cur;
      end else begin
        stalled = 0;
      end
      @(posedge clk); #1;
      eth_tx_tready = bp_mode ? ~eth_tx_tready : 1'b1;
      for (int i = 0; i < NP; i++) begin
        if (!rst_n) srcq[i].delete();
        else if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (srcq[i].size() > 0) begin
          b = srcq[i][0];
          if (b.gap > 0) begin
            b.gap--;
            srcq[i][0] = b;
            s_tvalid[i] = 1'b0;
          end else begin
            if (!s_tvalid[i]) rise_cyc[i] = cyc;
            s_tvalid[i] = 1'b1;
            s_tdata[i*64 +: 64] = b.d;
            s_tkeep[i*8 +: 8] = b.k;
            s_tlast[i] = b.l;
            s_tuser[i] = b.u;
          end
        end else begin
          s_tvalid[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    vec_t vt[4];
    int   port, fr;
    vt[0] = '{1, 3, 8'h0F, 1'b0, 2'd1, 2};
    vt[1] = '{2, 2, 8'hFF, 1'b1, 2'd2, 2};
    vt[2] = '{0, 1, 8'h01, 1'b0, 2'd0, 2};
    vt[3] = '{2, 4, 8'h3F, 1'b0, 2'd2, 2};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_tvalid", 64'(eth_tx_tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    chk("rst_abort_cnt", 64'(abort_cnt), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_out", {eth_tx_tdata[59:0], eth_tx_tkeep, eth_tx_tlast, eth_tx_tuser}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #3;
    outq.delete();

    // Single frames: pass-through, latency, grant and tuser.
    for (int v = 0; v < 4; v++) begin
      outq.delete();
      push_frame(vt[v].src, v, vt[v].nb, vt[v].last_keep, vt[v].last_user);
      wait_out(vt[v].nb, 40, "tbl_done");
      for (int b = 0; b < vt[v].nb; b++) begin
        chk_beat("tbl_beat", b, mk(vt[v].src, v, b),
                 (b == vt[v].nb-1) ? vt[v].last_keep : 8'hFF, b == vt[v].nb-1,
                 (b == vt[v].nb-1) ? vt[v].last_user : 1'b0);
      end
      if (outq.size() > 0)
        chk("tbl_latency", 64'(outq[0].cyc - rise_cyc[vt[v].src]), 64'(vt[v].exp_lat));
      chk("tbl_grant", 64'(grant_idx), 64'(vt[v].exp_grant));
      repeat (3) @(negedge clk);
      chk("tbl_no_dup", 64'(outq.size()), 64'(vt[v].nb));
      chk("tbl_busy", 64'(busy), 64'd0);
      chk("tbl_abort_cnt", 64'(abort_cnt), 64'd0);
    end

    // Round robin: all sources continuously valid, 2 frames of 2 beats each.
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < NP; p++) push_frame(p, f, 2, 8'hFF, 1'b0);
    wait_out(12, 100, "rr_done");
    for (int k = 0; k < 12 && k < outq.size(); k++) begin
      port = (k / 2) % 3;
      fr   = (k / 2) / 3;
      chk("rr_order", outq[k].d, mk(port, fr, k % 2));
      if (k > 0) chk("rr_gap", 64'(outq[k].cyc - outq[k-1].cyc), (k % 2 == 0) ? 64'd2 : 64'd1);
    end

    // Backpressure: MAC ready toggles every cycle during a 4-beat frame.
    do_reset();
    bp_mode = 1;
    push_frame(1, 7, 4, 8'h07, 1'b0);
    wait_out(4, 60, "bp_done");
    bp_mode = 0;
    for (int b = 0; b < 4; b++)
      chk_beat("bp_beat", b, mk(1, 7, b), (b == 3) ? 8'h07 : 8'hFF, b == 3, 1'b0);
    repeat (4) @(negedge clk);
    chk("bp_no_dup", 64'(outq.size()), 64'd4);
    chk("bp_abort_cnt", 64'(abort_cnt), 64'd0);

    // Watchdog: source 0 stalls mid-frame; source 1 waits its turn.
    do_reset();
    push_beat(0, mk(0, 9, 0), 8'hFF, 1'b0, 1'b0, 0);
    push_beat(0, mk(0, 9, 1), 8'hFF, 1'b0, 1'b0, 14);
    push_beat(0, mk(0, 9, 2), 8'h03, 1'b1, 1'b0, 0);
    push_frame(1, 9, 2, 8'hFF, 1'b0);
    wait_out(4, 100, "wd_done");
    chk_beat("wd_first", 0, mk(0, 9, 0), 8'hFF, 1'b0, 1'b0);
    chk_beat("wd_abort", 1, 64'd0, 8'h01, 1'b1, 1'b1);
    chk_beat("wd_next0", 2, mk(1, 9, 0), 8'hFF, 1'b0, 1'b0);
    chk_beat("wd_next1", 3, mk(1, 9, 1), 8'hFF, 1'b1, 1'b0);
    chk("wd_abort_cnt", 64'(abort_cnt), 64'd1);
    chk("wd_grant", 64'(grant_idx), 64'd1);
    chk("wd_drained", 64'(srcq[0].size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("wd_out_count", 64'(outq.size()), 64'd4);

    // Reset in the middle of a frame from source 2.
    do_reset();
    push_frame(0, 3, 1, 8'h01, 1'b0);
    wait_out(1, 30, "rst_pre");
    repeat (2) @(negedge clk);
    outq.delete();
    push_frame(2, 4, 4, 8'hFF, 1'b0);
    wait_out(2, 30, "rst_beat2");
    chk("rst_mid_grant_pre", 64'(grant_idx), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", 64'(eth_tx_tvalid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_grant", 64'(grant_idx), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #3;
    outq.delete();
    push_frame(1, 5, 1, 8'h01, 1'b0);
    push_frame(0, 5, 1, 8'h01, 1'b0);
    push_frame(2, 5, 1, 8'h01, 1'b0);
    wait_out(3, 40, "rst_post");
    for (int k = 0; k < 3; k++) chk_beat("rst_rr", k, mk(k, 5, 0), 8'h01, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
